sort_result_reader: RTL and testbench
=====================================

Name: sort_result_reader

Overview:
- Read-side companion to the sort system: after the sort controller signals completion, streams the N sorted words out of the shared single-port RAM over a valid/ready interface.
- Sits beside the controller and RAM; owns the RAM address/read port only while busy (RAM write side stays with the sort datapath).
- Decouples synchronous RAM read latency from downstream backpressure via an internal 2-entry buffer; full throughput of one word per cycle when m_ready is held high.

Parameters:
- K, 8, data word width in bits
- N, 8, number of RAM words to stream (addresses 0..N-1)
- AW, 3, RAM address width; must satisfy 2**AW >= N

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  pulse: begin streaming; sampled only in IDLE
- rd_en  output  1  RAM read strobe
- rd_addr  output  AW  RAM read address, valid when rd_en=1
- rd_data  input  K  RAM read data, valid the cycle after rd_en
- m_valid  output  1  output word valid
- m_data  output  K  output word
- m_last  output  1  high with word N-1
- m_ready  input  1  downstream accepts word when m_valid & m_ready
- busy  output  1  high from accepted start until final handshake
- done  output  1  one-cycle pulse after final handshake

Behaviour:
- Reset (rst=0, async): state IDLE; rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0; buffer and counters cleared. Reset mid-stream abandons transfer; no done pulse.
- States: IDLE -> FETCH on start; FETCH -> DRAIN when read for address N-1 issued; DRAIN -> DONE on handshake of word N-1; DONE -> IDLE unconditionally (done=1 only in DONE, one cycle).
- start ignored outside IDLE. busy=1 in FETCH and DRAIN.
- Read issue: in FETCH, rd_en=1 when (count + inflight - pop) < 2; count = buffer occupancy 0..2, inflight = 0/1 read issued last cycle, pop = handshake this cycle. rd_addr increments 0..N-1 after each issued read; no wrap, no read of address >= N.
- Latency: start accepted at edge E0 -> first rd_en in cycle after E0; rd_data captured into buffer one cycle later; m_valid high the following cycle (2 cycles after first rd_en).
- Buffer: 2-entry FIFO; push on inflight, pop on handshake; simultaneous push and pop legal; overflow impossible by issue rule. m_data = head entry, m_valid = (count != 0).
- m_valid, m_data, m_last stable while m_valid=1 and m_ready=0.
- m_last travels with word N-1 (tagged at push); m_last=0 when m_valid=0.
- m_ready high continuously: words on N consecutive cycles.
- m_ready may toggle arbitrarily; m_ready with m_valid=0 has no effect.

Optional Feature:
- Macro SORTED_CHECK_EN. Defined: extra output port sort_err (1 bit); each handshaken word compared unsigned with previous handshaken word of the same stream; if smaller, sort_err set; sticky until next accepted start or reset; reset value 0. Not defined: port and comparison logic absent, all other behaviour identical.

Decomposition:
- Shared package sort_pkg: reader state enum (IDLE, FETCH, DRAIN, DONE), default K/N/AW constants shared with the sort datapath and controller.
- One sub-module: rd_skid_fifo (2-entry, width K+1 for data plus last tag, count output).

Test Plan:
- RAM = {3,7,12,20,33,41,90,200}, m_ready=1, start pulse -> first m_valid 3 cycles after start edge, 8 consecutive beats in address order, m_last on 200, done one cycle after last beat, busy low with done.
- Same RAM, m_ready = 1,0,0,1 repeating -> all 8 words in order, none dropped or duplicated, m_data stable while stalled, rd_en never issued when buffer+inflight full.
- m_ready=0 for 10 cycles after start -> exactly 2 reads issued (addr 0,1), m_valid held with word 3; release -> remaining 6 fetched, order preserved.
- start pulsed again during stream and during DONE -> ignored; single 8-word stream, one done pulse.
- rst asserted at beat 4 -> all outputs 0 immediately, no done; new start -> full 8-word stream from address 0.
- SORTED_CHECK_EN, RAM = {1,2,5,4,6,7,8,9} -> sort_err rises after handshake of 4, stays 1 through done, clears on next start; ascending RAM -> sort_err stays 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared sort-system definitions: reader FSM states and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents:
//   SORT_K / SORT_N / SORT_AW - default word width, word count, RAM address width
//   rd_state_e                - result reader state encoding
package sort_pkg;

  localparam int SORT_K  = 8;
  localparam int SORT_N  = 8;
  localparam int SORT_AW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that absorbs RAM read data while the consumer stalls.
// Latency: pushed entry visible at head one cycle after push.
// Backpressure: none internally; the caller must never push when full.
// Ports:
//   clk, rst            - clock, async active-low reset
//   push, push_dat      - write strobe and entry
//   pop                 - remove head entry (caller guarantees count != 0)
//   head_dat            - current head entry
//   count               - occupancy 0..2
module rd_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_dat;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    // push and pop in the same cycle leave occupancy unchanged
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/sort_result_reader.sv
// Streams the N sorted words out of the shared RAM over valid/ready once the sort completes.
// Latency: first m_valid two cycles after the first rd_en; one word per cycle with m_ready high.
// Backpressure: reads throttled so buffered + in-flight words never exceed two; output held while stalled.
// Optional feature macro: SORTED_CHECK_EN adds sort_err, a sticky flag for any descending pair.
// Ports:
//   clk, rst                  - clock, async active-low reset
//   start                     - begin a stream (honoured in IDLE only)
//   rd_en, rd_addr, rd_data   - RAM read port (data returns the cycle after rd_en)
//   m_valid, m_data, m_last,
//   m_ready                   - output stream, m_last marks word N-1
//   busy, done                - stream in progress / one-cycle completion pulse
//   sort_err                  - (SORTED_CHECK_EN only) order violation seen this stream
module sort_result_reader
  import sort_pkg::*;
#(
  parameter int K  = SORT_K,
  parameter int N  = SORT_N,
  parameter int AW = SORT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [K-1:0]  rd_data,
  output logic          m_valid,
  output logic [K-1:0]  m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
`ifdef SORTED_CHECK_EN
  ,
  output logic          sort_err
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  rd_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [1:0]    fifo_count;
  logic [K:0]    fifo_head;
  logic [2:0]    occ_after_pop;
  logic          pop;
  logic          issue;
  logic          is_last_rd;
  logic          start_acc;
  logic          head_vld;

  assign head_vld   = (fifo_count != 2'd0);
  assign pop        = head_vld & m_ready;
  assign is_last_rd = (addr_q == LAST_ADDR);
  assign start_acc  = (state_q == IDLE) & start;

  // Space check counts the word already in flight and credits this cycle's pop,
  // so a new read never lands in a full buffer yet full rate is sustained.
  assign occ_after_pop = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue         = (state_q == FETCH) && (occ_after_pop < 3'd2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: begin
        if (issue) begin
          if (is_last_rd) begin
            state_d = DRAIN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // the last tag lives with the data, so the final beat is recognised at the head
        if (pop && fifo_head[K]) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    inflight_d      = issue;
    inflight_last_d = issue & is_last_rd;
    busy_d          = (state_d == FETCH) || (state_d == DRAIN);
    done_d          = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  rd_skid_fifo #(
    .W (K + 1)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_dat ({inflight_last_q, rd_data}),
    .pop      (pop),
    .head_dat (fifo_head),
    .count    (fifo_count)
  );

  assign rd_en   = issue;
  assign rd_addr = addr_q;
  assign m_valid = head_vld;
  // stale head contents are masked so idle outputs read as zero
  assign m_data  = head_vld ? fifo_head[K-1:0] : '0;
  assign m_last  = head_vld & fifo_head[K];
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef SORTED_CHECK_EN
  logic         sort_err_q, sort_err_d;
  logic [K-1:0] prev_q, prev_d;
  logic         have_prev_q, have_prev_d;

  always_comb begin
    sort_err_d  = sort_err_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if (start_acc) begin
      sort_err_d  = 1'b0;
      have_prev_d = 1'b0;
    end else if (pop) begin
      if (have_prev_q && (fifo_head[K-1:0] < prev_q)) sort_err_d = 1'b1;
      prev_d      = fifo_head[K-1:0];
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sort_err_q  <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      sort_err_q  <= sort_err_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign sort_err = sort_err_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_sort_result_reader.sv
// Self-checking bench for sort_result_reader: directed scenarios with random RAM data and backpressure.
// Latency: n/a.
// Backpressure: m_ready driven by fixed patterns and $urandom.
module tb_sort_result_reader;

  localparam int K  = 8;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic [K-1:0]  rd_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          m_valid;
  logic [K-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic          done;
`ifdef SORTED_CHECK_EN
  logic          sort_err;
`endif

  sort_result_reader #(.K(K), .N(N), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done)
`ifdef SORTED_CHECK_EN
    ,
    .sort_err(sort_err)
`endif
  );

  always #5 clk = ~clk;

  // synchronous-read RAM model
  logic [K-1:0] ram [N];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // ---------------- monitor ----------------
  int           cyc = 0;
  int           issued = 0;
  int           addr_err = 0;
  int           ovf_err = 0;
  int           stable_err = 0;
  int           done_n = 0;
  int           done_cyc = 0;
  logic         done_busy = 1'b0;
  logic         done_err = 1'b0;
  int           cur_addr = 0;
  int           out_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [K-1:0] prev_data = '0;
  logic         prev_last = 1'b0;
  logic [K-1:0] rx_dat [1024];
  logic         rx_last [1024];
  int           rx_cyc [1024];
  logic         rx_err [1024];
  int           rx_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur_addr   = 0;
        out_cnt    = 0;
        stall_prev = 1'b0;
      end else begin
        logic hs;
        logic cur_err;
        cyc++;
        cur_err = 1'b0;
`ifdef SORTED_CHECK_EN
        cur_err = sort_err;
`endif
        hs = m_valid & m_ready;
        if (rd_en === 1'b1) begin
          if (cur_addr >= N || rd_addr !== AW'(cur_addr)) addr_err++;
          cur_addr++;
          issued++;
          out_cnt++;
        end
        if (stall_prev && !(m_valid === 1'b1 && m_data === prev_data && m_last === prev_last))
          stable_err++;
        if (m_valid === 1'b0 && (m_last !== 1'b0)) stable_err++;
        if (hs === 1'b1) begin
          rx_dat[rx_n]  = m_data;
          rx_last[rx_n] = m_last;
          rx_cyc[rx_n]  = cyc;
          rx_err[rx_n]  = cur_err;
          rx_n++;
          out_cnt--;
        end
        if (out_cnt > 2) ovf_err++;
        stall_prev = m_valid & ~m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (done === 1'b1) begin
          done_n++;
          done_cyc  = cyc;
          done_busy = busy;
          done_err  = cur_err;
          cur_addr  = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Entered at posedge+1. Drives m_ready per mode until done is seen; returns at negedge+1.
  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random
  task automatic run_stream(input int mode, input int start_at, input int budget, output bit ok);
    int d0;
    d0 = done_n;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      start = (c == start_at);
      @(negedge clk); #1;
      if (done_n != d0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int base, input bit consec);
    int last_i;
    last_i = base + N - 1;
    check($sformatf("%s_count", tag), rx_n - base, N);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_word%0d", tag, i), rx_dat[base+i], ram[i]);
      check($sformatf("%s_last%0d", tag, i), rx_last[base+i], (i == N - 1));
    end
    if (consec) check($sformatf("%s_back2back", tag), rx_cyc[last_i] - rx_cyc[base], N - 1);
    check($sformatf("%s_done_after_last", tag), done_cyc, rx_cyc[last_i] + 1);
    check($sformatf("%s_busy_at_done", tag), done_busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check($sformatf("%s_rd_en", tag), rd_en, 0);
    check($sformatf("%s_rd_addr", tag), rd_addr, 0);
    check($sformatf("%s_m_valid", tag), m_valid, 0);
    check($sformatf("%s_m_data", tag), m_data, 0);
    check($sformatf("%s_m_last", tag), m_last, 0);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_done", tag), done, 0);
  endtask

  task automatic load_fixed();
    logic [K-1:0] v [N];
    v = '{8'd3, 8'd7, 8'd12, 8'd20, 8'd33, 8'd41, 8'd90, 8'd200};
    for (int i = 0; i < N; i++) ram[i] = v[i];
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int base;
    int i0;
    int d0;

    load_fixed();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    #2 rst = 1'b1;

    // 1: full throughput and start-to-valid latency
    m_ready = 1'b1;
    base = rx_n;
    start_pulse();
    @(negedge clk);
    check("lat_c1_m_valid", m_valid, 0);
    check("lat_c1_busy", busy, 1);
    @(negedge clk);
    check("lat_c2_m_valid", m_valid, 0);
    @(negedge clk);
    check("lat_c3_m_valid", m_valid, 1);
    check("lat_c3_m_data", m_data, ram[0]);
    @(posedge clk); #1;
    run_stream(0, -1, 200, ok);
    check("full_done_seen", ok, 1);
    check_stream("full", base, 1'b1);

    // 2: periodic backpressure
    @(posedge clk); #1;
    m_ready = 1'b1;
    base = rx_n;
    start_pulse();
    run_stream(1, -1, 300, ok);
    check("pat_done_seen", ok, 1);
    check_stream("pat", base, 1'b0);

    // 3: long stall right after start
    @(posedge clk); #1;
    m_ready = 1'b0;
    base = rx_n;
    i0 = issued;
    start_pulse();
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    check("stall_reads", issued - i0, 2);
    check("stall_m_valid", m_valid, 1);
    check("stall_m_data", m_data, ram[0]);
    @(posedge clk); #1;
    run_stream(0, -1, 200, ok);
    check("stall_done_seen", ok, 1);
    check_stream("stall", base, 1'b0);

    // 4: random data, random ready, start re-pulsed mid-stream and in DONE
    for (int i = 0; i < N; i++) ram[i] = K'($urandom);
    @(posedge clk); #1;
    base = rx_n;
    i0 = issued;
    d0 = done_n;
    start_pulse();
    run_stream(2, 5, 400, ok);
    check("rnd_done_seen", ok, 1);
    check_stream("rnd", base, 1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rnd_single_done", done_n - d0, 1);
    check("rnd_single_stream", rx_n - base, N);
    check("rnd_reads", issued - i0, N);
    check("rnd_idle_busy", busy, 0);

    // 5: reset at beat 4, then a fresh stream
    load_fixed();
    m_ready = 1'b1;
    base = rx_n;
    start_pulse();
    for (int c = 0; c < 50 && (rx_n - base) < 4; c++) begin
      @(negedge clk); #1;
    end
    check("rst_beats_before", rx_n - base, 4);
    #1 rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    d0 = done_n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", done_n - d0, 0);
    base = rx_n;
    start_pulse();
    run_stream(0, -1, 200, ok);
    check("after_rst_done_seen", ok, 1);
    check_stream("after_rst", base, 1'b1);

`ifdef SORTED_CHECK_EN
    // 6: order checker against a descent-counting model
    begin
      logic [K-1:0] v [N];
      bit           seen;
      v = '{8'd1, 8'd2, 8'd5, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};
      for (int i = 0; i < N; i++) ram[i] = v[i];
      for (int pass = 0; pass < 2; pass++) begin
        if (pass == 1) begin
          // ascending random contents
          int acc;
          acc = 0;
          for (int i = 0; i < N; i++) begin
            acc += $urandom_range(0, 30);
            ram[i] = K'(acc);
          end
        end
        @(posedge clk); #1;
        base = rx_n;
        start_pulse();
        run_stream(2, -1, 400, ok);
        check($sformatf("chk%0d_done_seen", pass), ok, 1);
        seen = 1'b0;
        for (int i = 0; i < N; i++) begin
          // flag seen at beat i reflects only beats before it
          check($sformatf("chk%0d_err_beat%0d", pass, i), rx_err[base+i], seen);
          if (i > 0 && ram[i] < ram[i-1]) seen = 1'b1;
        end
        check($sformatf("chk%0d_err_at_done", pass), done_err, seen);
        check($sformatf("chk%0d_err_held", pass), sort_err, seen);
      end
    end
`endif

    check("rd_addr_order", addr_err, 0);
    check("buffer_overflow", ovf_err, 0);
    check("stall_stability", stable_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
